// File: rtl/seq_alu.sv
// Multi-cycle add/sub/mul/div unit with a START/DONE handshake, shift-add multiplier and
// restoring divider. Define SEQ_ALU_SIGNED_EN to add the SGN port for two's complement operands.
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         OP_CODE,
`ifdef SEQ_ALU_SIGNED_EN
  input  logic               SGN,
`endif
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               NEG,
  output logic               DIV_ZERO
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;
  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpDiv = 2'b11} op_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    result_q, result_d;
  logic             neg_q, neg_d, dz_q, dz_d;
  logic             sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;

  logic sgn_in;
`ifdef SEQ_ALU_SIGNED_EN
  assign sgn_in = SGN;
`else
  assign sgn_in = 1'b0;
`endif

  // Capture-cycle arithmetic for the single-cycle ops and operand magnitudes.
  logic [WIDTH:0]   ext_a, ext_b, add_s, sub_s;
  logic [WIDTH-1:0] abs_diff, mag_a, mag_b;
  logic             neg_a_in, neg_b_in;

  assign neg_a_in = sgn_in & A[WIDTH-1];
  assign neg_b_in = sgn_in & B[WIDTH-1];
  assign ext_a    = {neg_a_in, A};
  assign ext_b    = {neg_b_in, B};
  assign add_s    = ext_a + ext_b;
  assign sub_s    = ext_a - ext_b;
  assign abs_diff = (A >= B) ? (A - B) : (B - A);
  assign mag_a    = neg_a_in ? (~A + WIDTH'(1)) : A;
  assign mag_b    = neg_b_in ? (~B + WIDTH'(1)) : B;

  // Multiply step: acc = {partial high, remaining multiplier bits}, LSB first.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step;

  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_step   = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_step;

  assign div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, opnd_q}) : div_trial[WIDTH-1:0];
  assign div_step  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // Sign fixup applied to the magnitude result in the extra signed cycle.
  logic             fix_neg;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [W2-1:0]    fix_prod;

  assign fix_neg  = sa_q ^ sb_q;
  assign fix_quo  = fix_neg ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign fix_rem  = sa_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
  assign fix_prod = fix_neg ? (~acc_q + W2'(1)) : acc_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          op_d  = OP_CODE;
          sgn_d = sgn_in;
          sa_d  = neg_a_in;
          sb_d  = neg_b_in;
          cnt_d = '0;
          dz_d  = 1'b0;
          neg_d = 1'b0;
          unique case (op_e'(OP_CODE))
            OpAdd: begin
              result_d = sgn_in ? {{(WIDTH-1){add_s[WIDTH]}}, add_s}
                                : {{(WIDTH-1){1'b0}}, add_s};
              neg_d    = sgn_in & add_s[WIDTH];
              state_d  = StFin;
            end
            OpSub: begin
              result_d = sgn_in ? {{(WIDTH-1){sub_s[WIDTH]}}, sub_s}
                                : {{WIDTH{1'b0}}, abs_diff};
              neg_d    = sgn_in ? sub_s[WIDTH] : (A < B);
              state_d  = StFin;
            end
            OpMul: begin
              opnd_d  = mag_a;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              state_d = StCalc;
            end
            OpDiv: begin
              if (B == '0) begin
                result_d = {A, {WIDTH{1'b1}}};
                dz_d     = 1'b1;
                state_d  = StFin;
              end else begin
                opnd_d  = mag_b;
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                state_d = StCalc;
              end
            end
          endcase
        end
      end
      StCalc: begin
        if (sgn_q && (cnt_q == CntLast)) begin
          if (op_q == OpMul) begin
            result_d = fix_prod;
            neg_d    = fix_prod[W2-1];
          end else begin
            result_d = {fix_rem, fix_quo};
            neg_d    = fix_quo[WIDTH-1];
          end
          state_d = StFin;
        end else begin
          acc_d = (op_q == OpMul) ? mul_step : div_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (!sgn_q && (cnt_d == CntLast)) begin
            result_d = acc_d;
            neg_d    = 1'b0;
            state_d  = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      sgn_q    <= sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

  assign BUSY     = (state_q == StCalc);
  assign DONE     = (state_q == StFin);
  assign RESULT   = result_q;
  assign NEG      = neg_q;
  assign DIV_ZERO = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu (WIDTH=8, unsigned build) against an
// arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [1:0]    op_code;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic          neg;
  logic          div_zero;
`ifdef SEQ_ALU_SIGNED_EN
  logic          sgn = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .A        (a_in),
    .B        (b_in),
    .OP_CODE  (op_code),
`ifdef SEQ_ALU_SIGNED_EN
    .SGN      (sgn),
`endif
    .BUSY     (busy),
    .DONE     (done),
    .RESULT   (result),
    .NEG      (neg),
    .DIV_ZERO (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_result(input logic [1:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    case (op)
      2'd0:    return 16'(ia + ib);
      2'd1:    return 16'((ia >= ib) ? ia - ib : ib - ia);
      2'd2:    return 16'(ia * ib);
      default: begin
        if (ib == 0) return {a, 8'hff};
        return {8'(ia % ib), 8'(ia / ib)};
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [7:0] b);
    if (op == 2'd2 || (op == 2'd3 && b != 0)) return W + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit poke_calc, input bit poke_fin);
    logic [15:0] exp_res;
    int exp_lat;
    int lat;
    int busy_n;
    exp_res = model_result(op, a, b);
    exp_lat = model_latency(op, b);
    @(negedge clk);
    start = 1'b1; op_code = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); op_code = 2'($urandom);
    lat = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (poke_calc && lat == 3) begin
        start = 1'b1; a_in = 8'd3; b_in = 8'd5; op_code = 2'b00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_val("done_seen", done, 1);
    check_val("latency", lat, exp_lat);
    check_val("busy_cycles", busy_n, exp_lat - 1);
    check_val("result", result, exp_res);
    check_val("neg", neg, (op == 2'd1 && a < b) ? 1 : 0);
    check_val("div_zero", div_zero, (op == 2'd3 && b == 0) ? 1 : 0);
    if (poke_fin) begin
      start = 1'b1; op_code = 2'b00; a_in = 8'd1; b_in = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check_val("fin_start_ignored", {busy, done}, 0);
      check_val("fin_result_hold", result, exp_res);
    end
  endtask

  initial begin
    logic [15:0] held;
    int seen;
    logic [1:0] rop;
    logic [7:0] ra, rb;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; op_code = '0;
    repeat (2) @(negedge clk);
    start = 1'b1; op_code = 2'b00; a_in = 8'd1; b_in = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check_val("rst_outputs", {busy, done, result, neg, div_zero}, 0);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check_val("rst_start_ignored", seen, 0);

    run_op(2'd0, 8'd200, 8'd100, 1'b0, 1'b0);
    run_op(2'd1, 8'd5, 8'd9, 1'b0, 1'b0);
    run_op(2'd1, 8'd7, 8'd7, 1'b0, 1'b0);
    run_op(2'd2, 8'd255, 8'd255, 1'b0, 1'b0);
    run_op(2'd2, 8'd0, 8'd77, 1'b0, 1'b0);
    run_op(2'd2, 8'd13, 8'd11, 1'b1, 1'b0);
    run_op(2'd3, 8'd200, 8'd7, 1'b0, 1'b0);
    run_op(2'd0, 8'd10, 8'd20, 1'b0, 1'b1);
    run_op(2'd3, 8'd9, 8'd0, 1'b0, 1'b0);

    held = result;
    repeat (3) @(negedge clk);
    check_val("result_hold", result, held);
    check_val("done_low_idle", done, 0);

    // Abort a divide in the middle of its iterations.
    start = 1'b1; op_code = 2'b11; a_in = 8'd200; b_in = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_outputs", {busy, done, result, neg, div_zero}, 0);
    seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_val("abort_no_done", seen, 0);
    run_op(2'd0, 8'd255, 8'd255, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      run_op(rop, ra, rb, 1'b0, (i % 7) == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
